// File: rtl/step_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_ctrl_pkg: shared state encoding and snapshot select codes | Rev 1.0
// ---------------------------------------------------------------------------
package step_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_IDLE    = 3'd1,
    S_PULSE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } step_state_t;

  localparam logic [2:0] STAT_STALL  = 3'd0;
  localparam logic [2:0] STAT_ARITH  = 3'd1;
  localparam logic [2:0] STAT_MEM    = 3'd2;
  localparam logic [2:0] STAT_CYCLES = 3'd3;
  localparam logic [2:0] STAT_INSTR  = 3'd4;
  localparam int         STAT_COUNT  = 5;

endpackage
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// input_debouncer: 2-FF synchronizer followed by a stability counter | Rev 1.0
// ---------------------------------------------------------------------------
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;

  // The counter tracks how many consecutive samples disagree with the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      level   <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        level <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/step_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// step_controller: run/step debug driver with performance-counter snapshots | Rev 1.0
// ---------------------------------------------------------------------------
module step_controller
  import step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PULSE_CYCLES    = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clkFPGA,
  input  logic             rst,
  input  logic             step_mode_sw,
  input  logic             next_btn,
  input  logic             finish,
  input  logic [CNT_W-1:0] R28_stall_count,
  input  logic [CNT_W-1:0] R29_aritmetric_count,
  input  logic [CNT_W-1:0] R30_memory_count,
  input  logic [CNT_W-1:0] cycles,
  input  logic [CNT_W-1:0] instr_count,
  input  logic [2:0]       stat_sel,
  output logic             stepping_flag,
  output logic             next_instr,
  output logic [CNT_W-1:0] stat_out,
  output logic             done
);

  localparam int c_pulse_w = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [c_pulse_w-1:0] c_pulse_last = c_pulse_w'(PULSE_CYCLES - 1);

  logic                 w_sw_db;
  logic                 w_btn_db;
  logic                 r_btn_db_q;
  logic                 w_btn_rise;
  step_state_t          r_state;
  step_state_t          w_state_nxt;
  logic [c_pulse_w-1:0] r_pulse_cnt;
  logic [c_pulse_w-1:0] w_pulse_cnt_nxt;
  logic                 w_take_snap;
  logic                 r_stepping;
  logic                 r_next;
  logic                 r_done;
  logic [CNT_W-1:0]     r_snap [STAT_COUNT];
  logic [CNT_W-1:0]     r_stat_out;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk   (clkFPGA),
    .rst   (rst),
    .raw   (step_mode_sw),
    .level (w_sw_db)
  );

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk   (clkFPGA),
    .rst   (rst),
    .raw   (next_btn),
    .level (w_btn_db)
  );

  assign w_btn_rise = w_btn_db & ~r_btn_db_q;

  always_comb begin
    w_state_nxt     = r_state;
    w_pulse_cnt_nxt = '0;
    case (r_state)
      S_RUN:     if (w_sw_db) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_btn_rise)    w_state_nxt = S_PULSE;
        else if (!w_sw_db) w_state_nxt = S_RUN;
      end
      S_PULSE: begin
        if (r_pulse_cnt == c_pulse_last) w_state_nxt = S_RELEASE;
        else                             w_pulse_cnt_nxt = r_pulse_cnt + 1'b1;
      end
      S_RELEASE: if (!w_btn_db) w_state_nxt = S_IDLE;
      S_DONE:    w_state_nxt = S_DONE;
      default:   w_state_nxt = S_RUN;
    endcase
    if (finish) w_state_nxt = S_DONE;
    // A finish that truncates a pulse satisfies both triggers but still yields one copy.
    w_take_snap = ((r_state == S_PULSE) && (w_state_nxt != S_PULSE)) ||
                  (finish && (r_state != S_DONE));
  end

  // Outputs are decoded from the next state and registered with it, so they switch with the state.
  always_ff @(posedge clkFPGA or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_pulse_cnt <= '0;
      r_btn_db_q  <= 1'b0;
      r_stepping  <= 1'b0;
      r_next      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_btn_db_q  <= w_btn_db;
      r_stepping  <= (w_state_nxt != S_RUN);
      r_next      <= (w_state_nxt == S_PULSE);
      r_done      <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clkFPGA or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAT_COUNT; i++) r_snap[i] <= '0;
      r_stat_out <= '0;
    end else begin
      if (w_take_snap) begin
        r_snap[STAT_STALL]  <= R28_stall_count;
        r_snap[STAT_ARITH]  <= R29_aritmetric_count;
        r_snap[STAT_MEM]    <= R30_memory_count;
        r_snap[STAT_CYCLES] <= cycles;
        r_snap[STAT_INSTR]  <= instr_count;
      end
      case (stat_sel)
        STAT_STALL:  r_stat_out <= r_snap[STAT_STALL];
        STAT_ARITH:  r_stat_out <= r_snap[STAT_ARITH];
        STAT_MEM:    r_stat_out <= r_snap[STAT_MEM];
        STAT_CYCLES: r_stat_out <= r_snap[STAT_CYCLES];
        STAT_INSTR:  r_stat_out <= r_snap[STAT_INSTR];
        default:     r_stat_out <= '0;
      endcase
    end
  end

  assign stepping_flag = r_stepping;
  assign next_instr    = r_next;
  assign done          = r_done;
  assign stat_out      = r_stat_out;

endmodule
`default_nettype wire

// File: tb/tb_step_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_step_controller: scoreboard bench with a snapshot reference model | Rev 1.0
// ---------------------------------------------------------------------------
module tb_step_controller;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] val;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sw;
  logic        btn;
  logic        finish;
  logic [2:0]  stat_sel;
  logic [31:0] ctr [5];
  logic        stepping_flag;
  logic        next_instr;
  logic [31:0] stat_out;
  logic        done;
  logic        rd_req;

  logic [31:0] model_snap [5];
  rd_exp_t     stat_q [$];
  int          pulse_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  step_controller #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2), .CNT_W(32)) dut (
    .clkFPGA              (clk),
    .rst                  (rst),
    .step_mode_sw         (sw),
    .next_btn             (btn),
    .finish               (finish),
    .R28_stall_count      (ctr[0]),
    .R29_aritmetric_count (ctr[1]),
    .R30_memory_count     (ctr[2]),
    .cycles               (ctr[3]),
    .instr_count          (ctr[4]),
    .stat_sel             (stat_sel),
    .stepping_flag        (stepping_flag),
    .next_instr           (next_instr),
    .stat_out             (stat_out),
    .done                 (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] exp_stat(input logic [2:0] sel);
    int idx;
    idx = int'(sel);
    if (idx < 5) return model_snap[idx];
    return 32'd0;
  endfunction

  task automatic take_model_snap();
    for (int i = 0; i < 5; i++) model_snap[i] = ctr[i];
  endtask

  task automatic clear_model();
    for (int i = 0; i < 5; i++) model_snap[i] = 32'd0;
  endtask

  task automatic rand_ctrs();
    for (int i = 0; i < 5; i++) ctr[i] = $urandom;
  endtask

  task automatic read_stat(input logic [2:0] sel);
    rd_exp_t e;
    cyc();
    stat_sel = sel;
    e.sel    = sel;
    e.val    = exp_stat(sel);
    stat_q.push_back(e);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic read_all();
    for (int s = 0; s < 8; s++) read_stat(3'(s));
  endtask

  task automatic press_btn(input bit glitch, input int hold);
    if (glitch) begin
      btn = 1'b1; cyc(); cyc();
      btn = 1'b0; cyc(); cyc();
    end
    btn = 1'b1;
    repeat (hold) cyc();
    btn = 1'b0;
    repeat (15) cyc();
  endtask

  // Debounced mode change must reach stepping_flag within 7 clock edges.
  task automatic wait_stepping(input logic exp, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (stepping_flag !== exp && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check(name, stepping_flag, exp);
    checks++;
    if (n > 7) begin
      errors++;
      $display("FAIL %s_latency: got %0d cycles expected at most 7", name, n);
    end
  endtask

  task automatic monitor();
    int      width;
    logic    rd_pend;
    rd_exp_t e;
    width   = 0;
    rd_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_pend && stat_q.size() > 0) begin
        e = stat_q.pop_front();
        check($sformatf("stat_sel%0d", e.sel), stat_out, e.val);
      end
      if (rst) begin
        width = 0;
      end else if (next_instr === 1'b1) begin
        width++;
        check("pulse_stepping", stepping_flag, 1'b1);
      end else if (width > 0) begin
        if (pulse_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got width %0d expected no pulse", width);
        end else begin
          check("pulse_width", width, pulse_q.pop_front());
        end
        width = 0;
      end
      rd_pend = rd_req;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int nsteps;
    int n;
    rst = 1'b1; sw = 1'b0; btn = 1'b0; finish = 1'b0; stat_sel = 3'd0; rd_req = 1'b0;
    for (int i = 0; i < 5; i++) ctr[i] = 32'd0;
    clear_model();
    fork monitor(); join_none

    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("reset_stepping", stepping_flag, 1'b0);
    check("reset_next", next_instr, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_stat", stat_out, 32'd0);
    read_all();

    cyc();
    sw = 1'b1;
    wait_stepping(1'b1, "step_entry");

    nsteps = $urandom_range(2, 4);
    for (int k = 0; k < nsteps; k++) begin
      cyc();
      rand_ctrs();
      if (k == 0) ctr[3] = 32'd123;
      pulse_q.push_back(2);
      press_btn((k == 0) ? 1'b1 : 1'($urandom % 2), 40);
      take_model_snap();
      rand_ctrs();
      if (k == 0) read_stat(3'd3);
      repeat (3) read_stat(3'($urandom_range(0, 7)));
    end
    read_all();

    // Button chatter that never settles must not step the datapath.
    for (int i = 0; i < 15; i++) begin
      btn = ~btn;
      cyc(); cyc();
    end
    btn = 1'b0;
    repeat (15) cyc();
    repeat (3) read_stat(3'($urandom_range(0, 7)));

    sw = 1'b0;
    wait_stepping(1'b0, "step_exit");
    cyc();
    rand_ctrs();
    press_btn(1'b0, 20);
    read_all();

    cyc();
    rand_ctrs();
    ctr[4] = 32'd57;
    finish = 1'b1;
    cyc();
    take_model_snap();
    @(negedge clk);
    check("finish_done", done, 1'b1);
    check("finish_stepping", stepping_flag, 1'b1);
    check("finish_next", next_instr, 1'b0);
    cyc();
    finish = 1'b0;
    read_stat(3'd4);
    rand_ctrs();
    sw = 1'b1;
    press_btn(1'b0, 20);
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    rand_ctrs();
    repeat (10) cyc();
    @(negedge clk);
    check("sticky_done", done, 1'b1);
    check("sticky_stepping", stepping_flag, 1'b1);
    check("sticky_next", next_instr, 1'b0);
    read_all();

    cyc();
    sw = 1'b0;
    btn = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    check("async_reset_done", done, 1'b0);
    check("async_reset_stepping", stepping_flag, 1'b0);
    clear_model();
    repeat (2) cyc();
    rst = 1'b0;
    read_all();

    cyc();
    sw = 1'b1;
    wait_stepping(1'b1, "step_entry2");
    rand_ctrs();
    pulse_q.push_back(1);
    btn = 1'b1;
    n = 0;
    while (next_instr !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("trunc_pulse_seen", next_instr, 1'b1);
    finish = 1'b1;
    take_model_snap();
    @(negedge clk);
    check("trunc_next", next_instr, 1'b0);
    check("trunc_done", done, 1'b1);
    finish = 1'b0;
    btn = 1'b0;
    rand_ctrs();
    repeat (15) cyc();
    read_all();

    repeat (5) cyc();
    check("pulse_q_empty", pulse_q.size(), 32'd0);
    check("stat_q_empty", stat_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
